// File: rtl/periph_bridge.sv
// Single-outstanding CPU-to-timer bridge: decodes a request, optionally stretches the
// timer access by ACCESS_WAIT cycles, and holds the response until the CPU takes it.
module periph_bridge #(
    parameter logic [31:0] TIMER_BASE  = 32'hFFFF_F000,
    parameter int unsigned ACCESS_WAIT = 0
) (
    input  logic        periph_clk,
    input  logic        periph_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] timer_addr,
    output logic        timer_we,
    output logic [31:0] timer_raw_wdata,
    input  logic [31:0] timer_wdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(ACCESS_WAIT);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wait_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_hs;
    logic        w_req_err;
    logic        w_last;

    assign w_hs      = req_valid && (r_state == S_IDLE);
    assign w_req_err = (req_addr[1:0] != 2'b00)
                    || (req_addr[31:3] != TIMER_BASE[31:3])
                    || (req_we && (req_wstrb != 4'hF));
    assign w_last    = (r_state == S_ACCESS) && (r_wait_cnt == LP_WAIT);

    always_ff @(posedge periph_clk) begin
        if (periph_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_hs) w_next = w_req_err ? S_RESP : S_ACCESS;
            S_ACCESS: if (w_last) w_next = S_RESP;
            S_RESP:   if (resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request latch, wait counter and response capture
    always_ff @(posedge periph_clk) begin
        if (periph_rst) begin
            r_wait_cnt <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
        end else if (w_hs) begin
            r_wait_cnt <= 4'd0;
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_wstrb    <= req_wstrb;
            r_err      <= w_req_err;
            r_rdata    <= 32'd0;
        end else if (r_state == S_ACCESS) begin
            if (!w_last) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end else if (!r_we) begin
                r_rdata <= timer_wdata;
            end
        end
    end

    // Outputs are also gated by reset so nothing leaks during the reset cycle itself
    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 32'd0;
        resp_err        = 1'b0;
        timer_addr      = 32'd0;
        timer_we        = 1'b0;
        timer_raw_wdata = 32'd0;
        if (!periph_rst) begin
            case (r_state)
                S_IDLE: begin
                    req_ready = 1'b1;
                end
                S_ACCESS: begin
                    timer_addr      = r_addr;
                    timer_raw_wdata = r_wdata;
                    timer_we        = w_last && r_we && (&r_wstrb);
                end
                S_RESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = r_rdata;
                    resp_err   = r_err;
                end
                default: begin
                    req_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bridge.sv
// Directed bench for periph_bridge: three instances (ACCESS_WAIT 0, 3, 2) share the request side.
module tb_periph_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready;
    logic [31:0] tb_val;

    logic        rdy   [3];
    logic        rvld  [3];
    logic        rerr  [3];
    logic        tw    [3];
    logic [31:0] rdat  [3];
    logic [31:0] taddr [3];
    logic [31:0] traw  [3];
    logic [31:0] twd   [3];

    int checks = 0;
    int errors = 0;

    // Timer model: offset 4 reads all-ones, everything else reads tb_val
    assign twd[0] = (taddr[0] == 32'hFFFF_F004) ? 32'hFFFF_FFFF : tb_val;
    assign twd[1] = (taddr[1] == 32'hFFFF_F004) ? 32'hFFFF_FFFF : tb_val;
    assign twd[2] = (taddr[2] == 32'hFFFF_F004) ? 32'hFFFF_FFFF : tb_val;

    periph_bridge #(.ACCESS_WAIT(0)) u0 (
        .periph_clk(clk), .periph_rst(rst),
        .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(rvld[0]), .resp_ready(resp_ready), .resp_rdata(rdat[0]),
        .resp_err(rerr[0]), .timer_addr(taddr[0]), .timer_we(tw[0]),
        .timer_raw_wdata(traw[0]), .timer_wdata(twd[0])
    );

    periph_bridge #(.ACCESS_WAIT(3)) u1 (
        .periph_clk(clk), .periph_rst(rst),
        .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(rvld[1]), .resp_ready(resp_ready), .resp_rdata(rdat[1]),
        .resp_err(rerr[1]), .timer_addr(taddr[1]), .timer_we(tw[1]),
        .timer_raw_wdata(traw[1]), .timer_wdata(twd[1])
    );

    periph_bridge #(.ACCESS_WAIT(2)) u2 (
        .periph_clk(clk), .periph_rst(rst),
        .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(rvld[2]), .resp_ready(resp_ready), .resp_rdata(rdat[2]),
        .resp_err(rerr[2]), .timer_addr(taddr[2]), .timer_we(tw[2]),
        .timer_raw_wdata(traw[2]), .timer_wdata(twd[2])
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          pulses;
        int          acc;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one request, follow it to resp_valid, check everything seen along the way
    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_lat, input int exp_pulses, input int exp_acc,
                          input string tag);
        int lat;
        int pulses;
        int acc;
        int busy_rdy;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        chk($sformatf("%s ready", tag), {31'd0, rdy[d]}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_wstrb = 4'd0;
        lat = 0; pulses = 0; acc = 0; busy_rdy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rdy[d]) busy_rdy++;
            if (taddr[d] != 32'd0) acc++;
            if (tw[d]) begin
                pulses++;
                chk($sformatf("%s pulse addr", tag), taddr[d], addr);
                chk($sformatf("%s pulse data", tag), traw[d], wdata);
            end
            if (rvld[d]) begin
                lat = k;
                break;
            end
        end
        chk($sformatf("%s latency", tag), lat, exp_lat);
        chk($sformatf("%s rdata", tag), rdat[d], exp_rd);
        chk($sformatf("%s err", tag), {31'd0, rerr[d]}, {31'd0, exp_err});
        chk($sformatf("%s we pulses", tag), pulses, exp_pulses);
        chk($sformatf("%s access cycles", tag), acc, exp_acc);
        chk($sformatf("%s ready while busy", tag), busy_rdy, 0);
        chk($sformatf("%s timer idle in resp", tag),
            {taddr[d] | traw[d]} | {31'd0, tw[d]}, 32'd0);
    endtask

    initial begin
        int pulses;

        vt[0] = '{1'b0, 32'hFFFF_F000, 32'h0,         4'h0, 1'b0, 32'h0000_0042, 2, 0, 1};
        vt[1] = '{1'b1, 32'hFFFF_F004, 32'h5,         4'hF, 1'b0, 32'h0,         2, 1, 1};
        vt[2] = '{1'b1, 32'hFFFF_F000, 32'h1234,      4'h3, 1'b1, 32'h0,         1, 0, 0};
        vt[3] = '{1'b0, 32'hFFFF_F002, 32'h0,         4'h0, 1'b1, 32'h0,         1, 0, 0};
        vt[4] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 1'b1, 32'h0,         1, 0, 0};
        vt[5] = '{1'b0, 32'hFFFF_F004, 32'h0,         4'h0, 1'b0, 32'hFFFF_FFFF, 2, 0, 1};
        vt[6] = '{1'b0, 32'hFFFF_F008, 32'h0,         4'h0, 1'b1, 32'h0,         1, 0, 0};
        vt[7] = '{1'b1, 32'hFFFF_F000, 32'hA5A5_5A5A, 4'hF, 1'b0, 32'h0,         2, 1, 1};
        vt[8] = '{1'b0, 32'hFFFF_F000, 32'h0,         4'h3, 1'b0, 32'h0000_0042, 2, 0, 1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_wstrb  = 4'd0;
        resp_ready = 1'b1;
        tb_val     = 32'h0000_0042;

        repeat (3) @(negedge clk);
        chk("reset resp_valid", {31'd0, rvld[0]}, 32'd0);
        chk("reset resp_rdata", rdat[0], 32'd0);
        chk("reset resp_err", {31'd0, rerr[0]}, 32'd0);
        chk("reset timer_we", {31'd0, tw[0]}, 32'd0);
        chk("reset timer_addr", taddr[0], 32'd0);
        chk("reset timer_raw_wdata", traw[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", {31'd0, rdy[0]}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            do_txn(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].err,
                   vt[i].rd, vt[i].lat, vt[i].pulses, vt[i].acc, $sformatf("vec%0d", i));
        end

        // ACCESS_WAIT=3 load with a stalled consumer
        do_reset();
        resp_ready = 1'b0;
        do_txn(1, 1'b0, 32'hFFFF_F000, 32'h0, 4'h0, 1'b0, 32'h0000_0042, 5, 0, 4, "wait3");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d resp_valid", i), {31'd0, rvld[1]}, 32'd1);
            chk($sformatf("stall%0d rdata", i), rdat[1], 32'h0000_0042);
            chk($sformatf("stall%0d err", i), {31'd0, rerr[1]}, 32'd0);
            chk($sformatf("stall%0d req_ready", i), {31'd0, rdy[1]}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("stall release resp_valid", {31'd0, rvld[1]}, 32'd0);
        chk("stall release req_ready", {31'd0, rdy[1]}, 32'd1);

        // ACCESS_WAIT=2 store interrupted by reset in its first ACCESS cycle
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'hFFFF_F000;
        req_wdata = 32'h7;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_wstrb = 4'd0;
        @(negedge clk);
        chk("abort first access addr", taddr[2], 32'hFFFF_F000);
        rst = 1'b1;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (tw[2]) pulses++;
        end
        chk("abort resp_valid", {31'd0, rvld[2]}, 32'd0);
        chk("abort resp_rdata", rdat[2], 32'd0);
        chk("abort resp_err", {31'd0, rerr[2]}, 32'd0);
        chk("abort timer_addr", taddr[2], 32'd0);
        chk("abort timer_raw_wdata", traw[2], 32'd0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (tw[2] || rvld[2]) pulses++;
        end
        chk("abort no late activity", pulses, 0);
        do_txn(2, 1'b1, 32'hFFFF_F004, 32'h9, 4'hF, 1'b0, 32'h0, 4, 1, 3, "after abort store");
        do_txn(2, 1'b0, 32'hFFFF_F004, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF, 4, 0, 3, "after abort load");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bridge.md
PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 Parameter TIMER_BASE, default 32'hFFFF_F000, byte address of the 8-byte timer window.
REQ-002 Parameter ACCESS_WAIT, default 0, extra wait cycles inserted before the timer strobe, range 0..15.
REQ-003 periph_clk  in  1  the only clock; all state updates on its rising edge.
REQ-004 periph_rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  CPU request present.
REQ-006 req_ready  out  1  bridge accepts the request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data.
REQ-010 req_wstrb  in  4  store byte enables.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  CPU consumes the response.
REQ-013 resp_rdata  out  32  load data; 0 for stores and errors.
REQ-014 resp_err  out  1  access rejected.
REQ-015 timer_addr  out  32  timer register address.
REQ-016 timer_we  out  1  timer write strobe.
REQ-017 timer_raw_wdata  out  32  timer write data.
REQ-018 timer_wdata  in  32  timer read data; combinational from timer_addr.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a handshake is req_valid & req_ready.
REQ-021 On handshake the bridge SHALL latch we, addr, wdata and wstrb, and take the error decision.
REQ-022 The error decision SHALL be: addr[1:0] != 0, or addr[31:3] != TIMER_BASE[31:3], or (we & wstrb != 4'hF).
REQ-023 An erroring request SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and SHALL NOT assert timer_we or drive the timer address.
REQ-024 A legal request SHALL go IDLE->ACCESS and stay in ACCESS for ACCESS_WAIT+1 cycles, tracked by a 4-bit wait counter.
REQ-025 During ACCESS, timer_addr SHALL equal the latched address and timer_raw_wdata SHALL equal the latched data.
REQ-026 timer_we SHALL be 1 only in the final ACCESS cycle and only for stores; it is a single-cycle pulse.
REQ-027 For loads, timer_wdata SHALL be captured into resp_rdata at the end of the final ACCESS cycle.
REQ-028 Reads at offset 4 SHALL pass through the timer's value (32'hFFFF_FFFF) unchanged, with resp_err=0.
REQ-029 Outside ACCESS, timer_addr, timer_raw_wdata and timer_we SHALL be 0.
REQ-030 Latency: handshake at cycle N gives resp_valid at N+2+ACCESS_WAIT for a legal request, and at N+1 for an erroring one.
REQ-031 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until resp_ready.
REQ-032 RESP with resp_ready SHALL return to IDLE; the next handshake is possible one cycle later, so at most one transaction is outstanding.
REQ-033 A req_valid arriving while not in IDLE SHALL be ignored and is not lost only if the CPU holds it.
REQ-034 A store SHALL return resp_rdata=0 and resp_err=0.

Reset
REQ-035 periph_rst=1 at a clock edge SHALL force IDLE and clear the wait counter and latched request.
REQ-036 periph_rst=1 SHALL force resp_valid=0, resp_rdata=0, resp_err=0, timer_we=0, timer_addr=0 and timer_raw_wdata=0; req_ready becomes 1 after reset releases.
REQ-037 A reset during ACCESS SHALL suppress the pending timer_we pulse; no partial transaction completes.

Verification
REQ-038 Load 0xFFFF_F000 with timer_wdata=32'h0000_0042 and ACCESS_WAIT=0 -> resp_valid two cycles after handshake, resp_rdata=0x42, resp_err=0.
REQ-039 Store 0xFFFF_F004 with wdata=5 and wstrb=F -> exactly one timer_we pulse with timer_addr=0xFFFF_F004 and timer_raw_wdata=5, then resp_err=0.
REQ-040 Store with wstrb=4'h3, load 0xFFFF_F002 and load 0x0000_1000 -> each gives resp_err=1, rdata=0, timer_we never asserted, response one cycle after handshake.
REQ-041 ACCESS_WAIT=3, load -> timer_addr held for 4 cycles, response at N+5; resp_ready held low 3 cycles -> response stable, req_ready=0 throughout.
REQ-042 Reset asserted in the first ACCESS cycle of a store with ACCESS_WAIT=2 -> no timer_we pulse, all outputs 0, and the next request completes normally.
